burst_producer: RTL and testbench

Parameterised traffic source driving the single-cycle `val`/`data` push interface that the accumulating consumer samples. Emits pseudo-random bytes from an 8-bit LFSR in fixed-length bursts separated by fixed idle gaps, optionally stopping after a set number of bursts. In parallel it keeps a reference running sum and a beat count, so a bench can check the consumer's `sum` directly against the producer.

---
 rtl/burst_producer.sv | 115 +++++++++++
 tb/tb_burst_producer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_producer.sv
// LFSR-driven burst traffic source with a reference running sum and beat count.
// Fixed-length bursts of pseudo-random bytes separated by fixed idle gaps.
//
// state | meaning
// IDLE  | waiting for en; LFSR, sum and beat count retained
// BURST | issuing beats until BURST_LEN have been sent
// GAP   | val held low for GAP_LEN cycles between bursts
// DONE  | NUM_BURSTS bursts complete; left only by rst
module burst_producer #(
    parameter logic [7:0]  SEED       = 8'hA5,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned GAP_LEN    = 2,
    parameter int unsigned NUM_BURSTS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        val,
    output logic [7:0]  data,
    output logic [7:0]  exp_sum,
    output logic [15:0] beat_total,
    output logic        busy,
    output logic        done
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int GW = $clog2(GAP_LEN + 1);
    localparam int NW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS + 1) : 1;

    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

    state_t          state, state_nxt;
    logic [7:0]      lfsr, lfsr_nxt;
    logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic [NW-1:0]   burst_cnt, burst_cnt_nxt;
    logic            issue;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1
    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    assign busy = (state == BURST) || (state == GAP);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            val        <= 1'b0;
            data       <= 8'h00;
            exp_sum    <= 8'h00;
            beat_total <= 16'h0000;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            burst_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            val       <= issue;
            if (issue) begin
                data       <= lfsr;
                lfsr       <= lfsr_nxt;
                exp_sum    <= exp_sum + lfsr;
                beat_total <= beat_total + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        issue         = 1'b0;
        beat_cnt_nxt  = beat_cnt;
        gap_cnt_nxt   = gap_cnt;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (en) begin
                    issue        = 1'b1;
                    beat_cnt_nxt = BW'(1);
                    state_nxt    = BURST;
                end
            end
            BURST: begin
                if (beat_cnt < BW'(BURST_LEN)) begin
                    issue        = 1'b1;
                    beat_cnt_nxt = beat_cnt + BW'(1);
                end else begin
                    burst_cnt_nxt = burst_cnt + NW'(1);
                    if ((NUM_BURSTS != 0) && (burst_cnt_nxt == NW'(NUM_BURSTS))) begin
                        state_nxt = DONE;
                    end else begin
                        gap_cnt_nxt = GW'(1);
                        state_nxt   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt < GW'(GAP_LEN)) begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end else if (en) begin
                    issue        = 1'b1;
                    beat_cnt_nxt = BW'(1);
                    state_nxt    = BURST;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_burst_producer.sv
// Self-checking bench for burst_producer: default, NUM_BURSTS=2 and 1/1 burst/gap variants.
// Expected beats are queued by the stimulus and popped by a negedge monitor.
module tb_burst_producer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en_def = 1'b0, en_nb = 1'b0, en_b1 = 1'b0;

    logic        d_val, d_busy, d_done;
    logic [7:0]  d_data, d_exp_sum;
    logic [15:0] d_beat_total;
    logic        n_val, n_busy, n_done;
    logic [7:0]  n_data, n_exp_sum;
    logic [15:0] n_beat_total;
    logic        b_val, b_busy, b_done;
    logic [7:0]  b_data, b_exp_sum;
    logic [15:0] b_beat_total;

    burst_producer u_def (
        .clk(clk), .rst(rst), .en(en_def), .val(d_val), .data(d_data),
        .exp_sum(d_exp_sum), .beat_total(d_beat_total), .busy(d_busy), .done(d_done)
    );

    burst_producer #(.NUM_BURSTS(2)) u_nb (
        .clk(clk), .rst(rst), .en(en_nb), .val(n_val), .data(n_data),
        .exp_sum(n_exp_sum), .beat_total(n_beat_total), .busy(n_busy), .done(n_done)
    );

    burst_producer #(.BURST_LEN(1), .GAP_LEN(1)) u_b1 (
        .clk(clk), .rst(rst), .en(en_b1), .val(b_val), .data(b_data),
        .exp_sum(b_exp_sum), .beat_total(b_beat_total), .busy(b_busy), .done(b_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Consumers that add data on the edge after val is presented
    logic [7:0] cons_def, cons_nb;
    always @(posedge clk) begin
        if (rst) begin
            cons_def <= 8'h00;
            cons_nb  <= 8'h00;
        end else begin
            if (d_val) cons_def <= cons_def + d_data;
            if (n_val) cons_nb  <= cons_nb + n_data;
        end
    end

    // Scoreboard for the default instance
    logic [7:0]  exp_q[$];
    logic [7:0]  mdl_sum;
    logic [15:0] mdl_total;
    logic [7:0]  mdl_beat;

    always @(negedge clk) begin
        if (rst) begin
            mdl_sum   = 8'h00;
            mdl_total = 16'h0000;
        end else if (d_val) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data %0h with val=1, required no beat", d_data);
            end else begin
                mdl_beat  = exp_q.pop_front();
                mdl_sum   = mdl_sum + mdl_beat;
                mdl_total = mdl_total + 16'd1;
                chk("sb_data", d_data, mdl_beat);
                chk("sb_exp_sum", d_exp_sum, mdl_sum);
                chk("sb_beat_total", d_beat_total, mdl_total);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        en_def = 1'b0;
        en_nb = 1'b0;
        en_b1 = 1'b0;
        exp_q.delete();
        tick;
        tick;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic       t1_val[10];
    logic       t3_val[7];
    logic       t6_val[5];
    logic [7:0] m;
    logic [7:0] prev_exp;
    int         nbeats;

    initial begin
        t1_val = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        t3_val = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        t6_val = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Defaults, en held: two bursts with a 2-cycle gap
        do_reset;
        chk("rst_val", d_val, 1'b0);
        chk("rst_exp_sum", d_exp_sum, 8'h00);
        chk("rst_beat_total", d_beat_total, 16'h0000);
        chk("rst_busy", d_busy, 1'b0);
        foreach (t1_val[i]) ;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h4A);
        exp_q.push_back(8'h95); exp_q.push_back(8'h2A);
        exp_q.push_back(8'h54); exp_q.push_back(8'hA9);
        exp_q.push_back(8'h53); exp_q.push_back(8'hA7);
        en_def = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            chk($sformatf("t1_val_c%0d", c), d_val, t1_val[c]);
            if (c == 3) chk("t1_exp_sum_first_burst", d_exp_sum, 8'hAE);
            if (c == 4) chk("t1_busy_in_gap", d_busy, 1'b1);
        end
        en_def = 1'b0;
        repeat (4) tick;
        chk("t1_idle_busy", d_busy, 1'b0);
        chk("t1_idle_done", d_done, 1'b0);
        chk("t1_queue_drained", exp_q.size(), 0);

        // NUM_BURSTS=2: stops in DONE after 8 beats
        do_reset;
        en_nb = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick;
            if (c == 4) chk("t2_busy_gap", n_busy, 1'b1);
            if (c == 9) begin
                chk("t2_last_data", n_data, 8'hA7);
                chk("t2_done_early", n_done, 1'b0);
            end
            if (c == 10) begin
                chk("t2_done", n_done, 1'b1);
                chk("t2_busy", n_busy, 1'b0);
                chk("t2_val", n_val, 1'b0);
                chk("t2_exp_sum", n_exp_sum, 8'hA5);
                chk("t2_beat_total", n_beat_total, 16'd8);
                chk("t2_consumer_sum", cons_nb, 8'hA5);
            end
            if (c == 14) begin
                chk("t2_val_stays_low", n_val, 1'b0);
                chk("t2_done_held", n_done, 1'b1);
                chk("t2_beat_total_held", n_beat_total, 16'd8);
            end
        end
        en_nb = 1'b0;

        // One-cycle en pulse: a full burst, gap, back to IDLE, then resume
        do_reset;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h4A);
        exp_q.push_back(8'h95); exp_q.push_back(8'h2A);
        en_def = 1'b1;
        tick;
        en_def = 1'b0;
        chk("t3_val_c0", d_val, t3_val[0]);
        for (int c = 1; c < 7; c++) begin
            tick;
            chk($sformatf("t3_val_c%0d", c), d_val, t3_val[c]);
            if (c == 5) chk("t3_busy_gap_end", d_busy, 1'b1);
        end
        chk("t3_back_to_idle", d_busy, 1'b0);
        chk("t3_exp_sum", d_exp_sum, 8'hAE);
        chk("t3_beat_total", d_beat_total, 16'd4);
        repeat (3) tick;
        chk("t3_idle_val", d_val, 1'b0);
        chk("t3_queue_drained", exp_q.size(), 0);
        exp_q.push_back(8'h54); exp_q.push_back(8'hA9);
        exp_q.push_back(8'h53); exp_q.push_back(8'hA7);
        en_def = 1'b1;
        tick;
        en_def = 1'b0;
        chk("t3_resume_data", d_data, 8'h54);
        repeat (8) tick;
        chk("t3_resume_drained", exp_q.size(), 0);
        chk("t3_resume_exp_sum", d_exp_sum, 8'hA5);
        chk("t3_resume_total", d_beat_total, 16'd8);

        // Reset in the middle of a burst
        do_reset;
        exp_q.push_back(8'hA5);
        en_def = 1'b1;
        tick;
        rst = 1'b1;
        en_def = 1'b0;
        exp_q.delete();
        tick;
        chk("t4_val", d_val, 1'b0);
        chk("t4_exp_sum", d_exp_sum, 8'h00);
        chk("t4_beat_total", d_beat_total, 16'h0000);
        chk("t4_busy", d_busy, 1'b0);
        rst = 1'b0;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h4A);
        exp_q.push_back(8'h95); exp_q.push_back(8'h2A);
        en_def = 1'b1;
        tick;
        en_def = 1'b0;
        chk("t4_restart_data", d_data, 8'hA5);
        repeat (7) tick;
        chk("t4_queue_drained", exp_q.size(), 0);

        // Long run: LFSR period, duty cycle, consumer tracking
        do_reset;
        m = 8'hA5;
        for (int i = 0; i < 664; i++) begin
            exp_q.push_back(m);
            m = lfsr_step(m);
        end
        en_def = 1'b1;
        prev_exp = 8'h00;
        nbeats = 0;
        for (int c = 0; c < 996; c++) begin
            tick;
            chk("t5_val_pattern", d_val, ((c % 6) < 4) ? 1'b1 : 1'b0);
            chk("t5_consumer_lag", cons_def, prev_exp);
            prev_exp = d_exp_sum;
            if (d_val) begin
                nbeats++;
                if (nbeats == 256) chk("t5_beat256_data", d_data, 8'hA5);
            end
        end
        en_def = 1'b0;
        chk("t5_beat_count", nbeats, 664);
        repeat (4) tick;
        chk("t5_queue_drained", exp_q.size(), 0);
        chk("t5_beat_total", d_beat_total, 16'd664);

        // BURST_LEN=1, GAP_LEN=1: alternating val
        do_reset;
        en_b1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk($sformatf("t6_val_c%0d", c), b_val, t6_val[c]);
            if (c == 0) chk("t6_data_c0", b_data, 8'hA5);
            if (c == 1) begin
                chk("t6_busy_gap", b_busy, 1'b1);
                chk("t6_done", b_done, 1'b0);
            end
            if (c == 2) chk("t6_data_c2", b_data, 8'h4A);
            if (c == 4) begin
                chk("t6_data_c4", b_data, 8'h95);
                chk("t6_exp_sum", b_exp_sum, 8'h84);
                chk("t6_beat_total", b_beat_total, 16'd3);
            end
        end
        en_b1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
